mips_mem_access_unit: RTL and testbench
=======================================

Name: mips_mem_access_unit

Overview:
- Initiator side of the data-memory interface: the MIPS load/store unit that drives the word-wide data RAM.
- Accepts one CPU load/store request at a time.
- Validates alignment and range, then issues read_en/write_en/address/data_write to the RAM.
- Performs read-modify-write for sb/sh, extracts and extends lb/lbu/lh/lhu results, and returns one response per request.

Parameters:
DATA_WIDTH, 32, RAM word width (fixed 32 for MIPS lanes)
SIZE, 32, RAM depth in words; word index >= SIZE is out of range
ADDR_WIDTH, 32, CPU byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
req_valid  in  1  CPU request present
req_ready  out  1  unit idle, request accepted when req_valid & req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-justified for sb/sh
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_error  out  1  qualifies resp_valid; misaligned, out-of-range or illegal size
mem_address  out  32  RAM word index = req_addr[31:2]
mem_data_write  out  32  RAM write data
mem_write_en  out  1  RAM write strobe
mem_read_en  out  1  RAM read strobe
mem_data_out  in  32  RAM read data, valid the cycle after mem_read_en

Behaviour:
- Reset (async, on reset=0):
  - state=IDLE.
  - resp_valid, resp_error, resp_rdata, mem_address, mem_data_write, mem_write_en and mem_read_en are all 0.
  - req_ready=1 once reset=1.
- Mid-operation reset: aborts the operation; no write, no resp_valid.
- All mem_* and resp_* outputs are registered.
- req_ready = (state==IDLE).
- mem_write_en and mem_read_en are never both 1.
- States: IDLE, RD, CAP, RMW_RD, RMW_MRG, WR, RESP.
- IDLE, on accept, captures the request (req_write, req_size, req_unsigned, req_addr, req_wdata). Error when any of:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= SIZE.
- Transitions from IDLE:
  - error -> RESP, resp_error=1, no RAM access;
  - load -> RD;
  - word store -> WR with mem_data_write=req_wdata;
  - byte/half store -> RMW_RD.
- RD / RMW_RD: mem_read_en=1 for exactly one cycle, mem_address=word index.
- CAP: samples mem_data_out and extracts the result, little-endian:
  - byte lane addr[1:0] -> bits [8*lane+7 : 8*lane];
  - half lane addr[1] -> bits [16*addr[1]+15 : 16*addr[1]];
  - sign-extend unless req_unsigned=1;
  - word passes through.
  - Next state: RESP.
- RMW_MRG: samples mem_data_out and replaces the addressed byte/half lane with req_wdata[7:0]/[15:0]; all other lanes unchanged. Next state: WR.
- WR: mem_write_en=1 for exactly one cycle. Next state: RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - resp_rdata holds the load result; 0 for stores and errors.
  - resp_error is 0 on success.
- No response backpressure; the CPU must accept resp_valid.
- Latency from accept cycle T to resp_valid: error T+1, word store T+2, load T+3, sb/sh T+4.
- req_valid is ignored while busy; it is not queued. The CPU holds it until req_ready.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP.
- req_unsigned is ignored for stores and word loads.

Test Plan:
1. sw 0x14 data 0x0000000B at T -> T+1 mem_write_en=1, mem_address=5, mem_data_write=0x0000000B; T+2 resp_valid=1, error=0. Then lw 0x14 -> resp_rdata=0x0000000B at T+3.
2. sw 0x08 0x80FF7F01, then:
   - lb 0x0B -> 0xFFFFFF80;
   - lbu 0x0B -> 0x00000080;
   - lh 0x0A -> 0xFFFF80FF;
   - lhu 0x08 -> 0x00007F01.
3. With word 2 = 0x80FF7F01:
   - sb 0x09 data 0xAA -> one mem_read_en then one mem_write_en with 0x80FFAA01, resp at T+4;
   - then sh 0x0A data 0x1234 -> RAM word = 0x1234AA01.
4. Each of lw 0x06, lh 0x03, sw 0x80 (index 32) and req_size=11 -> resp_valid at T+1 with resp_error=1, resp_rdata=0, no mem_read_en/mem_write_en.
5. reset=0 during the RMW_RD cycle of sb 0x09 -> outputs 0 immediately, no mem_write_en, no resp_valid; after release req_ready=1, a later lw 0x08 returns the old value.
6. req_valid held high across two lw requests -> second accepted only in the IDLE cycle after the first RESP; exactly two resp_valid pulses.

Source files
------------

// File: rtl/mips_mem_access_unit.sv
// MIPS load/store unit: drives a word-wide data RAM for one CPU request at a time.
// Handles alignment/range checks, sub-word load extraction and sb/sh read-modify-write.
module mips_mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, RD, CAP, RMW_RD, RMW_MRG, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] SIZE_W = ADDR_WIDTH'(SIZE);

    state_t                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [31:0]           mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_write_q, mem_data_write_d;
    logic                  mem_write_en_q, mem_write_en_d;
    logic                  mem_read_en_q, mem_read_en_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  req_err;
    logic [4:0]            lane_shift;
    logic [15:0]           rd_half;
    logic [7:0]            rd_byte;
    logic                  ext_bit;
    logic [DATA_WIDTH-1:0] load_result;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] lane_ins;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        word_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
        req_err  = (req_size == SZ_ILL)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (|req_addr[1:0]))
                 || (word_idx >= SIZE_W);
    end

    // Halves are 2-byte aligned, so one byte-granular shift serves both lane widths.
    always_comb begin
        lane_shift = {lane_q, 3'b000};
        rd_half    = 16'(mem_data_out >> lane_shift);
        rd_byte    = rd_half[7:0];
        ext_bit    = ~uns_q & ((size_q == SZ_BYTE) ? rd_byte[7] : rd_half[15]);
        case (size_q)
            SZ_BYTE: load_result = {{(DATA_WIDTH-8){ext_bit}}, rd_byte};
            SZ_HALF: load_result = {{(DATA_WIDTH-16){ext_bit}}, rd_half};
            default: load_result = mem_data_out;
        endcase
        lane_mask = ((size_q == SZ_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << lane_shift;
        lane_ins  = ((size_q == SZ_BYTE) ? DATA_WIDTH'(wdata_q[7:0]) : DATA_WIDTH'(wdata_q)) << lane_shift;
        merged    = (mem_data_out & ~lane_mask) | lane_ins;
    end

    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        uns_d            = uns_q;
        lane_d           = lane_q;
        wdata_d          = wdata_q;
        resp_valid_d     = 1'b0;
        resp_error_d     = 1'b0;
        resp_rdata_d     = '0;
        mem_address_d    = mem_address_q;
        mem_data_write_d = mem_data_write_q;
        mem_write_en_d   = 1'b0;
        mem_read_en_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write) begin
                        state_d       = RD;
                        mem_read_en_d = 1'b1;
                        mem_address_d = 32'(word_idx);
                    end else if (req_size == SZ_WORD) begin
                        state_d          = WR;
                        mem_write_en_d   = 1'b1;
                        mem_address_d    = 32'(word_idx);
                        mem_data_write_d = req_wdata;
                    end else begin
                        state_d       = RMW_RD;
                        mem_read_en_d = 1'b1;
                        mem_address_d = 32'(word_idx);
                    end
                end
            end
            RD:     state_d = CAP;
            RMW_RD: state_d = RMW_MRG;
            CAP: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_result;
            end
            RMW_MRG: begin
                state_d          = WR;
                mem_write_en_d   = 1'b1;
                mem_data_write_d = merged;
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            size_q           <= '0;
            uns_q            <= 1'b0;
            lane_q           <= '0;
            wdata_q          <= '0;
            resp_valid_q     <= 1'b0;
            resp_error_q     <= 1'b0;
            resp_rdata_q     <= '0;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
            mem_write_en_q   <= 1'b0;
            mem_read_en_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            size_q           <= size_d;
            uns_q            <= uns_d;
            lane_q           <= lane_d;
            wdata_q          <= wdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_error_q     <= resp_error_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_address_q    <= mem_address_d;
            mem_data_write_q <= mem_data_write_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_read_en_q    <= mem_read_en_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_error     = resp_error_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_data_write = mem_data_write_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_read_en    = mem_read_en_q;

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Bench for mips_mem_access_unit: synchronous RAM, per-cycle reference model and
// directed load/store/error/reset sequences with literal expected results.
module tb_mips_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_write;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_data_out;

    mips_mem_access_unit #(.DATA_WIDTH(32), .SIZE(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Data RAM: read data appears the cycle after mem_read_en.
    logic [31:0] ram [0:31];
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address[4:0]] <= mem_data_write;
        if (mem_read_en)  mem_data_out <= ram[mem_address[4:0]];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expected RAM contents plus the schedule of the one outstanding request.
    logic [31:0] model_mem [0:31];
    int          cyc          = 0;
    int          exp_resp_cyc = -10;
    int          exp_rd_cyc   = -10;
    int          exp_wr_cyc   = -10;
    logic [31:0] exp_addr     = '0;
    logic [31:0] exp_rdata    = '0;
    logic [31:0] exp_wdata    = '0;
    logic        exp_err      = 1'b0;
    int          acc_cnt      = 0;
    int          last_acc     = 0;
    int          resp_pulses  = 0;

    int unsigned m_a, m_idx, m_lane, m_shift, m_unit;
    logic [31:0] m_word, m_part, m_new;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_resp_cyc = -10;
            exp_rd_cyc   = -10;
            exp_wr_cyc   = -10;
        end else begin
            if (req_valid && req_ready) begin
                m_a     = req_addr;
                m_idx   = m_a / 4;
                m_lane  = m_a % 4;
                m_shift = 8 * m_lane;
                exp_err = (req_size == 2'd3) || (req_size == 2'd1 && (m_a % 2) != 0)
                       || (req_size == 2'd2 && m_lane != 0) || (m_idx >= 32);
                exp_addr   = m_idx;
                exp_rdata  = '0;
                exp_rd_cyc = -10;
                exp_wr_cyc = -10;
                if (exp_err) begin
                    exp_resp_cyc = cyc + 1;
                end else begin
                    m_word = model_mem[m_idx];
                    if (!req_write) begin
                        exp_rd_cyc   = cyc + 1;
                        exp_resp_cyc = cyc + 3;
                        if (req_size == 2'd0) begin
                            m_part = (m_word >> m_shift) % 256;
                            if (!req_unsigned && m_part >= 128) m_part = m_part - 256;
                            exp_rdata = m_part;
                        end else if (req_size == 2'd1) begin
                            m_part = (m_word >> m_shift) % 65536;
                            if (!req_unsigned && m_part >= 32768) m_part = m_part - 65536;
                            exp_rdata = m_part;
                        end else begin
                            exp_rdata = m_word;
                        end
                    end else if (req_size == 2'd2) begin
                        exp_wr_cyc   = cyc + 1;
                        exp_wdata    = req_wdata;
                        exp_resp_cyc = cyc + 2;
                    end else begin
                        m_unit       = (req_size == 2'd0) ? 256 : 65536;
                        m_part       = (m_word >> m_shift) % m_unit;
                        m_new        = req_wdata % m_unit;
                        exp_wdata    = m_word - (m_part << m_shift) + (m_new << m_shift);
                        exp_rd_cyc   = cyc + 1;
                        exp_wr_cyc   = cyc + 3;
                        exp_resp_cyc = cyc + 4;
                    end
                end
                acc_cnt++;
                last_acc = cyc;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_error", resp_error, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_mem_we", mem_write_en, 0);
            chk("rst_mem_re", mem_read_en, 0);
            chk("rst_mem_addr", mem_address, 0);
            chk("rst_mem_wdata", mem_data_write, 0);
        end else begin
            chk("req_ready", req_ready, (exp_resp_cyc >= cyc) ? 0 : 1);
            chk("resp_valid", resp_valid, (cyc == exp_resp_cyc) ? 1 : 0);
            if (cyc == exp_resp_cyc) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_error", resp_error, exp_err);
            end
            if (resp_valid) resp_pulses++;
            chk("mem_read_en", mem_read_en, (cyc == exp_rd_cyc) ? 1 : 0);
            if (cyc == exp_rd_cyc) chk("rd_address", mem_address, exp_addr);
            chk("mem_write_en", mem_write_en, (cyc == exp_wr_cyc) ? 1 : 0);
            if (cyc == exp_wr_cyc) begin
                chk("wr_address", mem_address, exp_addr);
                chk("wr_data", mem_data_write, exp_wdata);
                model_mem[exp_addr[4:0]] = exp_wdata;
            end
            chk("strobe_excl", mem_read_en & mem_write_en, 0);
        end
    end

    task automatic start_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d, output int acc);
        int n0;
        bit got;
        n0 = acc_cnt;
        got = 0;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != n0) got = 1;
        end
        req_valid = 1'b0;
        chk("accept_seen", got, 1);
        acc = last_acc;
    endtask

    task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat);
        int acc, lat;
        bit got;
        logic [31:0] rd;
        logic er;
        start_req(w, sz, u, a, d, acc);
        got = 0; lat = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1; lat = cyc - acc; rd = resp_rdata; er = resp_error;
            end
        end
        chk({name, "_resp_seen"}, got, 1);
        if (got) begin
            chk({name, "_latency"}, lat, e_lat);
            chk({name, "_rdata"}, rd, e_rdata);
            chk({name, "_error"}, er, e_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", cyc, 0);
        $fatal(1, "timeout");
    end

    int a1, a2, n0, p0, acc;
    bit got;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("ready_after_reset", req_ready, 1);
        @(posedge clk); #1;

        do_req("sw_14", 1, 2'd2, 0, 32'h14, 32'h0000000B, 32'h0, 0, 2);
        do_req("lw_14", 0, 2'd2, 0, 32'h14, 32'h0, 32'h0000000B, 0, 3);

        do_req("sw_08", 1, 2'd2, 0, 32'h08, 32'h80FF7F01, 32'h0, 0, 2);
        do_req("lb_0b",  0, 2'd0, 0, 32'h0B, 32'h0, 32'hFFFFFF80, 0, 3);
        do_req("lbu_0b", 0, 2'd0, 1, 32'h0B, 32'h0, 32'h00000080, 0, 3);
        do_req("lh_0a",  0, 2'd1, 0, 32'h0A, 32'h0, 32'hFFFF80FF, 0, 3);
        do_req("lhu_08", 0, 2'd1, 1, 32'h08, 32'h0, 32'h00007F01, 0, 3);

        do_req("sb_09", 1, 2'd0, 0, 32'h09, 32'h000000AA, 32'h0, 0, 4);
        chk("ram2_after_sb", ram[2], 32'h80FFAA01);
        do_req("sh_0a", 1, 2'd1, 0, 32'h0A, 32'h00001234, 32'h0, 0, 4);
        chk("ram2_after_sh", ram[2], 32'h1234AA01);
        do_req("lw_08", 0, 2'd2, 0, 32'h08, 32'h0, 32'h1234AA01, 0, 3);

        do_req("lw_06_mis", 0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1, 1);
        do_req("lh_03_mis", 0, 2'd1, 0, 32'h03, 32'h0, 32'h0, 1, 1);
        do_req("sw_80_oor", 1, 2'd2, 0, 32'h80, 32'hDEADBEEF, 32'h0, 1, 1);
        do_req("size_ill",  0, 2'd3, 0, 32'h00, 32'h0, 32'h0, 1, 1);

        // Abort an sb during its RAM read cycle.
        start_req(1, 2'd0, 0, 32'h09, 32'h00000055, acc);
        #2 reset = 1'b0;
        #1;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_read_en", mem_read_en, 0);
        chk("abort_write_en", mem_write_en, 0);
        chk("abort_mem_addr", mem_address, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("ready_after_abort", req_ready, 1);
        @(posedge clk); #1;
        chk("ram2_after_abort", ram[2], 32'h1234AA01);
        do_req("lw_08_abort", 0, 2'd2, 0, 32'h08, 32'h0, 32'h1234AA01, 0, 3);

        // Two loads with req_valid held continuously.
        n0 = acc_cnt; p0 = resp_pulses;
        req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h14; req_wdata = '0;
        req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (acc_cnt == n0 + 1) got = 1;
        end
        chk("b2b_first_accept", got, 1);
        a1 = last_acc;
        req_addr = 32'h08;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (acc_cnt == n0 + 2) got = 1;
        end
        chk("b2b_second_accept", got, 1);
        a2 = last_acc;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_accept_gap", a2 - a1, 4);
        chk("b2b_resp_pulses", resp_pulses - p0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
